// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command sequencer: state encoding, header default,
// error codes and packet byte positions.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_CTRL = 3'd1,
    ST_GET_ADDR = 3'd2,
    ST_GET_DATA = 3'd3,
    ST_GET_CSUM = 3'd4,
    ST_ISSUE    = 3'd5
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TMO  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

  localparam int IDX_HDR  = 0;
  localparam int IDX_CTRL = 1;
  localparam int IDX_ADDR = 2;
  localparam int IDX_DATA = 3;
  localparam int IDX_CSUM = 4;

  // States in which the inter-byte timeout is armed.
  function automatic logic is_get_state(input state_t s);
    return (s == ST_GET_CTRL) || (s == ST_GET_ADDR) ||
           (s == ST_GET_DATA) || (s == ST_GET_CSUM);
  endfunction

endpackage

// File: rtl/uart_cmd_tmo.sv
// Load / tick / expire down-counter for inter-byte supervision; expired is high
// while the count sits at zero.
module uart_cmd_tmo #(
  parameter int TMO_CYC = 1000,
  parameter int TMO_W   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam logic [TMO_W-1:0] RELOAD = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames UART bytes into HDR/CTRL/ADDR/DATA[/CSUM] packets and issues register commands.
// Define UART_CMD_CSUM_EN to require a trailing XOR checksum byte.
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [7:0] HDR     = HDR_DEFAULT,
  parameter int         TMO_CYC = 1000,
  parameter int         TMO_W   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_vld,
  input  logic [7:0] byte_data,
  output logic       cmd_vld,
  output logic       cmd_rw,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_wdata,
  input  logic       cmd_rdy,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt
);

  state_t     state, state_n;
  logic [7:0] ctrl_q, ctrl_n;
  logic [7:0] addr_q, addr_n;
  logic       cmd_rw_n;
  logic [7:0] cmd_addr_n, cmd_wdata_n;
  logic       err_n;
  logic [1:0] err_code_n;
  logic [7:0] drop_n;
  logic       tmo_load, tmo_tick, tmo_expired;
`ifdef UART_CMD_CSUM_EN
  logic [7:0] data_q, data_n;
  logic [7:0] acc_q, acc_n;
`endif

  uart_cmd_tmo #(
    .TMO_CYC(TMO_CYC),
    .TMO_W  (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .load   (tmo_load),
    .tick   (tmo_tick),
    .expired(tmo_expired)
  );

  always_comb begin
    state_n     = state;
    ctrl_n      = ctrl_q;
    addr_n      = addr_q;
    cmd_rw_n    = cmd_rw;
    cmd_addr_n  = cmd_addr;
    cmd_wdata_n = cmd_wdata;
    err_n       = 1'b0;
    err_code_n  = ERR_NONE;
    drop_n      = drop_cnt;
    tmo_load    = 1'b0;
    tmo_tick    = 1'b0;
`ifdef UART_CMD_CSUM_EN
    data_n      = data_q;
    acc_n       = acc_q;
`endif

    case (state)
      ST_IDLE: begin
        if (byte_vld) begin
          if (byte_data == HDR) begin
            state_n  = ST_GET_CTRL;
            tmo_load = 1'b1;
`ifdef UART_CMD_CSUM_EN
            acc_n    = '0;
`endif
          end else if (drop_cnt != 8'hFF) begin
            drop_n = drop_cnt + 8'd1;
          end
        end
      end

      ST_GET_CTRL: begin
        if (byte_vld) begin
          ctrl_n   = byte_data;
          tmo_load = 1'b1;
          state_n  = ST_GET_ADDR;
`ifdef UART_CMD_CSUM_EN
          acc_n    = acc_q ^ byte_data;
`endif
        end
      end

      ST_GET_ADDR: begin
        if (byte_vld) begin
          addr_n   = byte_data;
          tmo_load = 1'b1;
          state_n  = ST_GET_DATA;
`ifdef UART_CMD_CSUM_EN
          acc_n    = acc_q ^ byte_data;
`endif
        end
      end

      ST_GET_DATA: begin
        if (byte_vld) begin
          tmo_load = 1'b1;
`ifdef UART_CMD_CSUM_EN
          data_n   = byte_data;
          acc_n    = acc_q ^ byte_data;
          state_n  = ST_GET_CSUM;
`else
          cmd_rw_n    = ctrl_q[7];
          cmd_addr_n  = addr_q;
          cmd_wdata_n = byte_data;
          state_n     = ST_ISSUE;
`endif
        end
      end

`ifdef UART_CMD_CSUM_EN
      ST_GET_CSUM: begin
        if (byte_vld) begin
          if (byte_data == acc_q) begin
            cmd_rw_n    = ctrl_q[7];
            cmd_addr_n  = addr_q;
            cmd_wdata_n = data_q;
            state_n     = ST_ISSUE;
          end else begin
            err_n      = 1'b1;
            err_code_n = ERR_CSUM;
            state_n    = ST_IDLE;
          end
        end
      end
`endif

      // Stray bytes are flagged but never disturb the pending command.
      ST_ISSUE: begin
        if (byte_vld) begin
          err_n      = 1'b1;
          err_code_n = ERR_OVR;
        end
        if (cmd_rdy) begin
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // A byte landing in the expiry cycle wins over the timeout.
    if (is_get_state(state) && !byte_vld) begin
      if (tmo_expired) begin
        err_n      = 1'b1;
        err_code_n = ERR_TMO;
        state_n    = ST_IDLE;
      end else begin
        tmo_tick = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ctrl_q    <= '0;
      addr_q    <= '0;
      cmd_vld   <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      drop_cnt  <= '0;
    end else begin
      state     <= state_n;
      ctrl_q    <= ctrl_n;
      addr_q    <= addr_n;
      cmd_vld   <= (state_n == ST_ISSUE);
      cmd_rw    <= cmd_rw_n;
      cmd_addr  <= cmd_addr_n;
      cmd_wdata <= cmd_wdata_n;
      busy      <= (state_n != ST_IDLE);
      err       <= err_n;
      err_code  <= err_code_n;
      drop_cnt  <= drop_n;
    end
  end

`ifdef UART_CMD_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      acc_q  <= '0;
    end else begin
      data_q <= data_n;
      acc_q  <= acc_n;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a packet-level reference model.
module tb_uart_cmd_ctrl;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 1000;
`ifdef UART_CMD_CSUM_EN
  localparam int PLEN = 5;
`else
  localparam int PLEN = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_vld;
  logic [7:0] byte_data;
  logic       cmd_rdy;
  logic       cmd_vld;
  logic       cmd_rw;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;

  uart_cmd_ctrl #(
    .HDR    (8'hA5),
    .TMO_CYC(1000),
    .TMO_W  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .cmd_vld  (cmd_vld),
    .cmd_rw   (cmd_rw),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_rdy  (cmd_rdy),
    .busy     (busy),
    .err      (err),
    .err_code (err_code),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string cur_tag = "reset";
  int    vld_cycles = 0;
  int    cmd_count = 0;
  int    err_seen = 0;

  // Reference model: bytes of the packet being collected, idle gap since the last
  // accepted byte, and the command awaiting handshake.
  logic [7:0] pkt[$];
  int         silent;
  bit         pend;
  bit         m_rw;
  logic [7:0] m_addr, m_wdata;
  int         m_drop;
  bit         m_err;
  logic [1:0] m_code;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, obs, expv);
    end
  endtask

  task automatic modelReset();
    pkt.delete();
    silent  = 0;
    pend    = 1'b0;
    m_rw    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_drop  = 0;
    m_err   = 1'b0;
    m_code  = 2'd0;
  endtask

  task automatic modelStep(input bit vld, input logic [7:0] d, input bit rdy);
    m_err  = 1'b0;
    m_code = 2'd0;
    if (pend) begin
      if (vld) begin
        m_err  = 1'b1;
        m_code = 2'd3;
      end
      if (rdy) pend = 1'b0;
    end else if (pkt.size() == 0) begin
      if (vld) begin
        if (d == HDR) begin
          pkt.push_back(d);
          silent = 0;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end else if (vld) begin
      pkt.push_back(d);
      silent = 0;
      if (pkt.size() == PLEN) begin
        if (PLEN == 5 && pkt[PLEN-1] != (pkt[1] ^ pkt[2] ^ pkt[3])) begin
          m_err  = 1'b1;
          m_code = 2'd2;
        end else begin
          pend    = 1'b1;
          m_rw    = pkt[1][7];
          m_addr  = pkt[2];
          m_wdata = pkt[3];
        end
        pkt.delete();
      end
    end else begin
      silent++;
      if (silent == TMO) begin
        m_err  = 1'b1;
        m_code = 2'd1;
        pkt.delete();
      end
    end
  endtask

  task automatic compareAll();
    bit exp_busy;
    exp_busy = (pkt.size() != 0) || pend;
    checkOutput({cur_tag, ".status"},
                {19'd0, busy, cmd_vld, err, err_code, drop_cnt},
                {19'd0, exp_busy, pend, m_err, m_code, 8'(m_drop)});
    if (pend)
      checkOutput({cur_tag, ".cmd"}, {15'd0, cmd_rw, cmd_addr, cmd_wdata},
                  {15'd0, m_rw, m_addr, m_wdata});
  endtask

  task automatic applyStimulus(input bit vld, input logic [7:0] d, input bit rdy);
    byte_vld  = vld;
    byte_data = d;
    cmd_rdy   = rdy;
    @(posedge clk);
    modelStep(vld, d, rdy);
    #1;
    if (cmd_vld) vld_cycles++;
    if (cmd_vld && cmd_rdy === 1'b1 && pend == 1'b0) cmd_count++;
    if (err) err_seen++;
    compareAll();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), rdy);
  endtask

  task automatic sendPacket(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input bit good_csum, input bit rdy);
    logic [7:0] cs;
    cs = c ^ a ^ d;
    if (!good_csum) cs = cs ^ 8'h01;
    applyStimulus(1'b1, HDR, rdy);
    applyStimulus(1'b1, c, rdy);
    applyStimulus(1'b1, a, rdy);
    applyStimulus(1'b1, d, rdy);
    if (PLEN == 5) applyStimulus(1'b1, cs, rdy);
  endtask

  task automatic drainIssue(input int stray_pct);
    for (int i = 0; i < 200 && pend; i++) begin
      if (($urandom % 100) < stray_pct) applyStimulus(1'b1, 8'($urandom), ($urandom % 2) == 0);
      else applyStimulus(1'b0, 8'h00, ($urandom % 2) == 0);
    end
    if (pend) applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {19'd0, busy, cmd_vld, err, err_code, drop_cnt},
                {32'd0});
    checkOutput({tag, ".cmd"}, {15'd0, cmd_rw, cmd_addr, cmd_wdata}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int         gap;

    rst = 1'b1; byte_vld = 1'b0; byte_data = 8'h00; cmd_rdy = 1'b0;
    modelReset();
    #1;
    checkAllZero("reset.init");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2, 1'b0);

    // Write with consumer ready
    cur_tag = "write";
    vld_cycles = 0;
    sendPacket(8'h00, 8'h12, 8'h34, 1'b1, 1'b1);
    checkOutput("write.fields", {15'd0, cmd_vld, cmd_rw, cmd_addr, cmd_wdata}, {15'd0, 1'b1, 1'b0, 8'h12, 8'h34});
    idle(3, 1'b1);
    checkOutput("write.vld_cycles", 32'(vld_cycles), 32'd1);

    // Read held 20 cycles with a stray byte during the wait
    cur_tag = "read";
    vld_cycles = 0;
    sendPacket(8'h80, 8'h40, 8'h00, 1'b1, 1'b0);
    idle(5, 1'b0);
    err_seen = 0;
    applyStimulus(1'b1, 8'h55, 1'b0);
    checkOutput("read.overrun", {30'd0, err, 1'b0} | 32'(err_code), 32'd3 | 32'd2);
    idle(13, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    idle(2, 1'b0);
    checkOutput("read.vld_cycles", 32'(vld_cycles), 32'd20);

    // Timeout after exactly TMO idle cycles, then a byte landing on the last allowed cycle
    cur_tag = "tmo";
    applyStimulus(1'b1, HDR, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    idle(TMO - 1, 1'b0);
    checkOutput("tmo.before", {31'd0, err}, 32'd0);
    idle(1, 1'b0);
    checkOutput("tmo.fire", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
    idle(2, 1'b0);
    cur_tag = "tmo_edge";
    applyStimulus(1'b1, HDR, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    idle(TMO - 1, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b1);
    checkOutput("tmo_edge.accept", {30'd0, busy, err}, {30'd0, 1'b1, 1'b0});
    applyStimulus(1'b1, 8'h34, 1'b1);
    if (PLEN == 5) applyStimulus(1'b1, 8'h26, 1'b1);
    idle(3, 1'b1);

    // Noise bytes before a packet, then drop counter saturation
    cur_tag = "noise";
    applyStimulus(1'b1, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b1);
    sendPacket(8'h00, 8'h05, 8'h06, 1'b1, 1'b1);
    idle(2, 1'b1);
    checkOutput("noise.drop", 32'(drop_cnt), 32'(m_drop));
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom);
      if (b == HDR) b = 8'h5A;
      applyStimulus(1'b1, b, 1'b0);
    end
    checkOutput("noise.sat", 32'(drop_cnt), 32'hFF);

`ifdef UART_CMD_CSUM_EN
    cur_tag = "csum";
    applyStimulus(1'b1, HDR, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h12, 1'b1);
    applyStimulus(1'b1, 8'h34, 1'b1);
    applyStimulus(1'b1, 8'h27, 1'b1);
    checkOutput("csum.bad", {28'd0, cmd_vld, err, err_code}, {28'd0, 1'b0, 1'b1, 2'd2});
    idle(2, 1'b1);
    sendPacket(8'h00, 8'h12, 8'h34, 1'b1, 1'b1);
    checkOutput("csum.good", {31'd0, cmd_vld}, 32'd1);
    idle(2, 1'b1);
`endif

    // Asynchronous reset in the middle of a packet
    cur_tag = "rst_mid";
    applyStimulus(1'b1, HDR, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b0);
    byte_vld = 1'b0;
    rst = 1'b1;
    #1;
    checkAllZero("rst_mid.async");
    modelReset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1, 1'b0);
    sendPacket(8'h00, 8'h77, 8'h99, 1'b1, 1'b1);
    checkOutput("rst_mid.after", {14'd0, cmd_vld, cmd_rw, cmd_addr, cmd_wdata, err}, {14'd0, 1'b1, 1'b0, 8'h77, 8'h99, 1'b0});
    idle(2, 1'b1);

    // Randomized packets with random gaps, stall and stray bytes
    cur_tag = "rand_pkt";
    for (int p = 0; p < 150; p++) begin
      if (($urandom % 6) == 0) applyStimulus(1'b1, 8'($urandom), 1'b0);
      for (int k = 0; k < PLEN; k++) begin
        if (k == 0) b = HDR;
        else if (k == 4) b = pkt.size() >= 4 ? (pkt[1] ^ pkt[2] ^ pkt[3]) ^ (($urandom % 4) == 0 ? 8'h10 : 8'h00) : 8'($urandom);
        else b = 8'($urandom);
        applyStimulus(1'b1, b, ($urandom % 2) == 0);
        if (k < PLEN - 1) begin
          if (($urandom % 40) == 0) gap = TMO - 2 + int'($urandom % 3);
          else gap = int'($urandom % 4);
          idle(gap, 1'b0);
        end
      end
      drainIssue(15);
      idle(int'($urandom % 3), 1'b0);
    end

    // Free-running random traffic biased toward header bytes
    cur_tag = "rand_free";
    for (int c = 0; c < 3000; c++) begin
      b = (($urandom % 4) == 0) ? HDR : 8'($urandom);
      applyStimulus(($urandom % 3) == 0, b, ($urandom % 3) != 0);
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Packet sequencer placed after the UART byte receiver.
- Takes the receiver's byte stream (single-cycle valid pulse plus 8-bit data) and frames it into fixed-length command packets: header, control, address, data, optional checksum.
- Issues each decoded register read/write over a valid/ready command port.
- Supervises inter-byte timeout and reports framing errors to the register/control layer.

Parameters:
- HDR, 8'hA5, header byte that opens a packet.
- TMO_CYC, 1000, max clk cycles allowed between consecutive bytes of one packet (>=2).
- TMO_W, 10, width of the timeout counter; must satisfy 2^TMO_W > TMO_CYC.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous reset, active-high.
- byte_vld  input  1  one-cycle pulse: byte_data is valid (receiver ok).
- byte_data  input  8  received byte.
- cmd_vld  output  1  command pending.
- cmd_rw  output  1  1 = read, 0 = write (CTRL[7]).
- cmd_addr  output  8  register address.
- cmd_wdata  output  8  write data (don't-care for reads, still driven with the DATA byte).
- cmd_rdy  input  1  consumer accepts the command when cmd_vld & cmd_rdy.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle error pulse.
- err_code  output  2  valid with err: 1 = timeout, 2 = checksum, 3 = overrun.
- drop_cnt  output  8  saturating count of non-header bytes discarded in IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; cmd_vld=0, cmd_rw=0, cmd_addr=0, cmd_wdata=0, err=0, err_code=0, drop_cnt=0, busy=0; timeout counter=0; checksum accumulator=0. Reset mid-packet or mid-ISSUE abandons the packet with no err pulse.
- All outputs are registered.
- States: IDLE -> GET_CTRL -> GET_ADDR -> GET_DATA -> [GET_CSUM] -> ISSUE -> IDLE.
- IDLE:
  - byte_vld with byte_data==HDR -> GET_CTRL; timeout counter loaded with TMO_CYC-1.
  - byte_vld with any other value -> byte discarded, drop_cnt+1 (saturates at 255), stay in IDLE.
- GET_CTRL, GET_ADDR, GET_DATA, GET_CSUM:
  - Each byte_vld captures the byte into the CTRL/ADDR/DATA/CSUM register, reloads the counter to TMO_CYC-1, and advances the state.
  - A header-valued byte inside a packet is treated as data; there is no resync.
- Timeout:
  - In any GET_* state, each cycle without byte_vld decrements the counter.
  - If the counter is 0 and no byte_vld arrives -> err=1, err_code=1, state=IDLE.
  - Result: timeout fires exactly TMO_CYC cycles after the last accepted byte.
  - If byte_vld arrives in the expiry cycle, the byte wins: it is accepted, the counter reloads, and no error is raised.
- Final byte accepted (cycle N): state=ISSUE and cmd_vld=1 from cycle N+1. cmd_rw, cmd_addr and cmd_wdata are stable while cmd_vld=1.
- ISSUE:
  - Hold cmd_vld until cmd_vld & cmd_rdy; the cycle after the handshake, cmd_vld=0 and state=IDLE.
  - cmd_rdy may be high before cmd_vld; the transfer then completes in cycle N+1.
  - No timeout applies in ISSUE.
  - Any byte_vld in ISSUE, including the handshake cycle, is discarded with err=1, err_code=3; the pending command is unaffected.
- Only one err pulse per cycle. Timeout, checksum and overrun errors are mutually exclusive by state.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UART_CMD_CSUM_EN.
- Defined:
  - GET_DATA -> GET_CSUM.
  - The CSUM byte must equal CTRL^ADDR^DATA.
  - Match -> ISSUE.
  - Mismatch -> err=1, err_code=2, state=IDLE, no command issued.
- Undefined:
  - GET_CSUM, the accumulator and the compare logic are absent.
  - GET_DATA -> ISSUE directly; err_code 2 is never produced.

Decomposition:
- Package uart_ctrl_pkg holds:
  - state encoding constants (IDLE=0 .. ISSUE=5);
  - default HDR value;
  - error codes ERR_TMO=1, ERR_CSUM=2, ERR_OVR=3;
  - packet byte-index constants.
- One sub-module, uart_cmd_tmo:
  - load, tick and expire timer, parameterised by TMO_CYC/TMO_W;
  - reusable by other UART-side controllers.

Test Plan:
1. Write with cmd_rdy=1: bytes A5,00,12,34 (plus checksum 26 if enabled) -> one cycle of cmd_vld=1 with rw=0, addr=12, wdata=34, the cycle after the last byte; then busy=0.
2. Read with cmd_rdy=0 for 20 cycles: A5,80,40,00 -> cmd_vld held 20 cycles with stable rw=1, addr=40; transfer when cmd_rdy rises; a byte 55 sent during the wait -> err=1, code 3, command still delivered intact.
3. Timeout with TMO_CYC=1000: A5,00, then silence -> err code 1 exactly 1000 cycles after byte 00; state IDLE. Repeat with the next byte landing on cycle 1000 -> accepted, no error.
4. Noise: bytes 11,22,A5,00,05,06 -> drop_cnt=2, one write with addr=05, wdata=06; 300 non-header bytes -> drop_cnt saturates at FF.
5. UART_CMD_CSUM_EN: A5,00,12,34,27 -> err code 2, no cmd_vld; A5,00,12,34,26 -> command issued.
6. Reset: assert rst after A5,00,12 -> all outputs 0 immediately, no err; the following full packet decodes correctly.
